trap_sequencer: RTL and testbench

Multi-cycle controller that sequences trap entry and MRET return around the machine-mode CSR register file. It selects one event per trap from the exception/interrupt candidates (pipeline-stage exceptions, pending interrupts, MRET), stalls the pipeline and waits for it to drain. It then issues a single-cycle CSR trap write with the decoded cause and return-PC select, and finally redirects the fetch PC. It sits between the pipeline hazard unit and the CSR register file.

---
 rtl/trap_pkg.sv | 44 ++++
 rtl/trap_sequencer_if.sv | 34 +++
 rtl/trap_prio_enc.sv | 74 +++++++
 rtl/trap_sequencer.sv | 124 ++++++++++++
 tb/tb_trap_sequencer.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/trap_pkg.sv
// Shared encodings for the trap sequencer: FSM states, stage indices,
// return-PC selects, interrupt cause codes and per-stage kill masks.
package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOLD     = 3'd1,
    ST_COMMIT   = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_MRET     = 3'd4
  } state_e;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 3;

  localparam logic [1:0] PCSEL_IF  = 2'b00;
  localparam logic [1:0] PCSEL_ID  = 2'b01;
  localparam logic [1:0] PCSEL_EXE = 2'b11;
  localparam logic [1:0] PCSEL_MEM = 2'b10;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam logic [3:0] FLUSH_NONE = 4'b0000;
  localparam logic [3:0] FLUSH_IF   = 4'b0001;
  localparam logic [3:0] FLUSH_ID   = 4'b0011;
  localparam logic [3:0] FLUSH_EXE  = 4'b0111;
  localparam logic [3:0] FLUSH_MEM  = 4'b1111;
  localparam logic [3:0] FLUSH_ALL  = 4'b1111;

  // Kill mask for the faulting stage and everything younger; interrupts map to EXE.
  function automatic logic [3:0] flush_for(input logic [1:0] pc_sel);
    case (pc_sel)
      PCSEL_MEM: return FLUSH_MEM;
      PCSEL_EXE: return FLUSH_EXE;
      PCSEL_ID:  return FLUSH_ID;
      default:   return FLUSH_IF;
    endcase
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Bus between the pipeline hazard unit / CSR file (master) and the
// trap sequencer (slave).
interface trap_sequencer_if;
  logic [3:0]  exc_vld;
  logic [15:0] exc_code;
  logic [2:0]  irq_pend;
  logic [2:0]  irq_en;
  logic        mstatus_mie;
  logic        mret_req;
  logic        pipe_idle;

  logic        stall;
  logic [3:0]  flush;
  logic        trap_wr;
  logic        trap_int;
  logic [3:0]  trap_code;
  logic [1:0]  pc_sel;
  logic        mret_wr;
  logic        redirect_vld;
  logic        redirect_src;
  logic        drain_to;

  modport master (
    output exc_vld, exc_code, irq_pend, irq_en, mstatus_mie, mret_req, pipe_idle,
    input  stall, flush, trap_wr, trap_int, trap_code, pc_sel,
           mret_wr, redirect_vld, redirect_src, drain_to
  );

  modport slave (
    input  exc_vld, exc_code, irq_pend, irq_en, mstatus_mie, mret_req, pipe_idle,
    output stall, flush, trap_wr, trap_int, trap_code, pc_sel,
           mret_wr, redirect_vld, redirect_src, drain_to
  );
endinterface

// File: rtl/trap_prio_enc.sv
// Combinational selection of the single event to take: oldest exception,
// then MRET (only if MEM/EXE are clean), then enabled interrupts.
module trap_prio_enc
  import trap_pkg::*;
(
  input  logic [3:0]  exc_vld_i,
  input  logic [15:0] exc_code_i,
  input  logic [2:0]  irq_pend_i,
  input  logic [2:0]  irq_en_i,
  input  logic        mstatus_mie_i,
  input  logic        mret_req_i,
  output logic        take_o,
  output logic        is_mret_o,
  output logic        int_o,
  output logic [3:0]  code_o,
  output logic [1:0]  pc_sel_o
);

  logic [3:0] stage_code [4];
  logic [2:0] irq_act;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_stage_code
      assign stage_code[gi] = exc_code_i[4*gi +: 4];
    end
  endgenerate

  // Bit order is {MEI, MTI, MSI}.
  assign irq_act = irq_pend_i & irq_en_i & {3{mstatus_mie_i}};

  always_comb begin
    take_o    = 1'b0;
    is_mret_o = 1'b0;
    int_o     = 1'b0;
    code_o    = 4'd0;
    pc_sel_o  = PCSEL_IF;
    if (exc_vld_i[STG_MEM]) begin
      take_o   = 1'b1;
      code_o   = stage_code[STG_MEM];
      pc_sel_o = PCSEL_MEM;
    end else if (exc_vld_i[STG_EXE]) begin
      take_o   = 1'b1;
      code_o   = stage_code[STG_EXE];
      pc_sel_o = PCSEL_EXE;
    end else if (mret_req_i) begin
      take_o    = 1'b1;
      is_mret_o = 1'b1;
    end else if (exc_vld_i[STG_ID]) begin
      take_o   = 1'b1;
      code_o   = stage_code[STG_ID];
      pc_sel_o = PCSEL_ID;
    end else if (exc_vld_i[STG_IF]) begin
      take_o   = 1'b1;
      code_o   = stage_code[STG_IF];
      pc_sel_o = PCSEL_IF;
    end else if (irq_act[2]) begin
      take_o   = 1'b1;
      int_o    = 1'b1;
      code_o   = IRQ_MEI;
      pc_sel_o = PCSEL_EXE;
    end else if (irq_act[0]) begin
      take_o   = 1'b1;
      int_o    = 1'b1;
      code_o   = IRQ_MSI;
      pc_sel_o = PCSEL_EXE;
    end else if (irq_act[1]) begin
      take_o   = 1'b1;
      int_o    = 1'b1;
      code_o   = IRQ_MTI;
      pc_sel_o = PCSEL_EXE;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap-entry / MRET sequencer: picks an event in IDLE, stalls and drains the
// pipeline, issues one CSR trap write, then redirects fetch.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int DRAIN_MAX = 15,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  trap_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             int_q, int_d;
  logic [3:0]       code_q, code_d;
  logic [1:0]       pc_sel_q, pc_sel_d;
  logic             drain_to_q, drain_to_d;

  logic       take;
  logic       is_mret;
  logic       enc_int;
  logic [3:0] enc_code;
  logic [1:0] enc_pc_sel;

  trap_prio_enc u_prio (
    .exc_vld_i     (bus.exc_vld),
    .exc_code_i    (bus.exc_code),
    .irq_pend_i    (bus.irq_pend),
    .irq_en_i      (bus.irq_en),
    .mstatus_mie_i (bus.mstatus_mie),
    .mret_req_i    (bus.mret_req),
    .take_o        (take),
    .is_mret_o     (is_mret),
    .int_o         (enc_int),
    .code_o        (enc_code),
    .pc_sel_o      (enc_pc_sel)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    int_d      = int_q;
    code_d     = code_q;
    pc_sel_d   = pc_sel_q;
    drain_to_d = drain_to_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          cnt_d = '0;
          if (is_mret) begin
            state_d = ST_MRET;
          end else begin
            state_d  = ST_HOLD;
            int_d    = enc_int;
            code_d   = enc_code;
            pc_sel_d = enc_pc_sel;
          end
        end
      end
      ST_HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.pipe_idle) begin
          state_d = ST_COMMIT;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_COMMIT;
          drain_to_d = 1'b1;
        end
      end
      ST_COMMIT: state_d = ST_REDIRECT;
      ST_REDIRECT: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        int_d    = 1'b0;
        code_d   = 4'd0;
        pc_sel_d = PCSEL_IF;
      end
      ST_MRET: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      int_q      <= 1'b0;
      code_q     <= 4'd0;
      pc_sel_q   <= PCSEL_IF;
      drain_to_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_q      <= int_d;
      code_q     <= code_d;
      pc_sel_q   <= pc_sel_d;
      drain_to_q <= drain_to_d;
    end
  end

  // Strobes are pure state decodes so they can never leak outside their state.
  always_comb begin
    case (state_q)
      ST_HOLD:     bus.flush = flush_for(pc_sel_q);
      ST_REDIRECT: bus.flush = FLUSH_ALL;
      ST_MRET:     bus.flush = FLUSH_EXE;
      default:     bus.flush = FLUSH_NONE;
    endcase
  end

  assign bus.stall        = (state_q != ST_IDLE);
  assign bus.trap_wr      = (state_q == ST_COMMIT);
  assign bus.mret_wr      = (state_q == ST_MRET);
  assign bus.redirect_vld = (state_q == ST_REDIRECT) || (state_q == ST_MRET);
  assign bus.redirect_src = (state_q == ST_MRET);
  assign bus.trap_int     = int_q;
  assign bus.trap_code    = code_q;
  assign bus.pc_sel       = pc_sel_q;
  assign bus.drain_to     = drain_to_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: per-cycle expected output vectors are
// queued when a request is driven and compared as the DUT steps.
module tb_trap_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trap_sequencer_if bus ();

  trap_sequencer #(.DRAIN_MAX(15), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {stall, flush, trap_wr, trap_int, trap_code, pc_sel, mret_wr, redirect_vld, redirect_src, drain_to}
  logic [16:0] obs;
  assign obs = {bus.stall, bus.flush, bus.trap_wr, bus.trap_int, bus.trap_code,
                bus.pc_sel, bus.mret_wr, bus.redirect_vld, bus.redirect_src, bus.drain_to};

  typedef struct {
    string       tag;
    logic [16:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [16:0] mk(input bit st, input logic [3:0] fl, input bit tw,
                                     input bit ti, input logic [3:0] cd, input logic [1:0] ps,
                                     input bit mw, input bit rv, input bit rs, input bit dt);
    return {st, fl, tw, ti, cd, ps, mw, rv, rs, dt};
  endfunction

  task automatic push(input string tag, input logic [16:0] v, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.tag = tag;
      e.v   = v;
      sb.push_back(e);
    end
  endtask

  // HOLD x nhold, COMMIT, REDIRECT, then one IDLE cycle.
  task automatic push_trap(input string tag, input logic [3:0] fl, input bit ti,
                           input logic [3:0] cd, input logic [1:0] ps, input int nhold,
                           input bit dt_hold, input bit dt_after);
    push({tag, "_hold"},   mk(1, fl,    0, ti, cd, ps, 0, 0, 0, dt_hold),  nhold);
    push({tag, "_commit"}, mk(1, 4'h0,  1, ti, cd, ps, 0, 0, 0, dt_after), 1);
    push({tag, "_redir"},  mk(1, 4'hF,  0, ti, cd, ps, 0, 1, 0, dt_after), 1);
    push({tag, "_idle"},   mk(0, 4'h0,  0, 0,  4'h0, 2'b00, 0, 0, 0, dt_after), 1);
  endtask

  task automatic check_next();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $error("FAIL sb_empty: observed=%h expected=queued entry", obs);
    end else begin
      e = sb.pop_front();
      checks++;
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic clear_req();
    bus.exc_vld     = 4'b0000;
    bus.exc_code    = 16'h0000;
    bus.irq_pend    = 3'b000;
    bus.irq_en      = 3'b000;
    bus.mstatus_mie = 1'b0;
    bus.mret_req    = 1'b0;
  endtask

  // Sample the request on the next edge, withdraw it, then drain the scoreboard.
  task automatic run_seq();
    check_next();
    clear_req();
    while (sb.size() > 0) check_next();
  endtask

  initial begin
    rst = 1'b1;
    clear_req();
    bus.pipe_idle = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push("reset", mk(0, 4'h0, 0, 0, 4'h0, 2'b00, 0, 0, 0, 0), 1);
    checks++;
    assert (obs === sb[0].v) else begin
      errors++;
      $error("FAIL reset_state: observed=%h expected=%h", obs, sb[0].v);
    end
    void'(sb.pop_front());
    rst = 1'b0;
    push("idle", mk(0, 4'h0, 0, 0, 4'h0, 2'b00, 0, 0, 0, 0), 2);
    while (sb.size() > 0) check_next();

    // EXE exception, code 2
    bus.exc_vld  = 4'b0100;
    bus.exc_code = 16'h0200;
    push_trap("exe", 4'b0111, 0, 4'd2, 2'b11, 1, 0, 0);
    run_seq();

    // MEM beats IF
    bus.exc_vld  = 4'b1001;
    bus.exc_code = 16'h5001;
    push_trap("mem_if", 4'b1111, 0, 4'd5, 2'b10, 1, 0, 0);
    run_seq();

    // All interrupts enabled: MEI wins
    bus.irq_pend = 3'b111; bus.irq_en = 3'b111; bus.mstatus_mie = 1'b1;
    push_trap("irq_mei", 4'b0111, 1, 4'd11, 2'b11, 1, 0, 0);
    run_seq();

    // Global interrupt disable: stays idle
    bus.irq_pend = 3'b111; bus.irq_en = 3'b111; bus.mstatus_mie = 1'b0;
    push("irq_masked", mk(0, 4'h0, 0, 0, 4'h0, 2'b00, 0, 0, 0, 0), 3);
    check_next(); check_next();
    clear_req();
    check_next();

    // MSI outranks MTI
    bus.irq_pend = 3'b011; bus.irq_en = 3'b011; bus.mstatus_mie = 1'b1;
    push_trap("irq_msi", 4'b0111, 1, 4'd3, 2'b11, 1, 0, 0);
    run_seq();

    // Exception beats interrupt
    bus.exc_vld = 4'b0001; bus.exc_code = 16'h0000;
    bus.irq_pend = 3'b111; bus.irq_en = 3'b111; bus.mstatus_mie = 1'b1;
    push_trap("exc_over_irq", 4'b0001, 0, 4'd0, 2'b00, 1, 0, 0);
    run_seq();

    // MRET outranks an ID exception
    bus.mret_req = 1'b1; bus.exc_vld = 4'b0010; bus.exc_code = 16'h0030;
    push("mret", mk(1, 4'b0111, 0, 0, 4'h0, 2'b00, 1, 1, 1, 0), 1);
    push("mret_idle", mk(0, 4'h0, 0, 0, 4'h0, 2'b00, 0, 0, 0, 0), 1);
    run_seq();

    // MEM exception outranks MRET
    bus.mret_req = 1'b1; bus.exc_vld = 4'b1000; bus.exc_code = 16'h4000;
    push_trap("mret_vs_mem", 4'b1111, 0, 4'd4, 2'b10, 1, 0, 0);
    run_seq();

    // Drain timeout: HOLD lasts DRAIN_MAX cycles
    bus.pipe_idle = 1'b0;
    bus.exc_vld = 4'b0100; bus.exc_code = 16'h0600;
    push_trap("drain_to", 4'b0111, 0, 4'd6, 2'b11, 15, 0, 1);
    run_seq();
    push("drain_sticky", mk(0, 4'h0, 0, 0, 4'h0, 2'b00, 0, 0, 0, 1), 2);
    while (sb.size() > 0) check_next();

    // Reset in the middle of HOLD
    bus.exc_vld = 4'b0010; bus.exc_code = 16'h0070;
    push("rst_hold", mk(1, 4'b0011, 0, 0, 4'd7, 2'b01, 0, 0, 0, 1), 2);
    run_seq();
    rst = 1'b1;
    push("rst_idle", mk(0, 4'h0, 0, 0, 4'h0, 2'b00, 0, 0, 0, 0), 1);
    check_next();
    rst = 1'b0;
    bus.pipe_idle = 1'b1;
    push("post_rst", mk(0, 4'h0, 0, 0, 4'h0, 2'b00, 0, 0, 0, 0), 3);
    while (sb.size() > 0) check_next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
